// File: rtl/div_if.sv
// Handshake/data bundle between the EX stage (master) and the iterative
// divider (slave).
//   signed_div_i  EX -> div  1 = DIV (signed), 0 = DIVU
//   opdata1_i     EX -> div  dividend
//   opdata2_i     EX -> div  divisor
//   start_i       EX -> div  request, held high until ready_o is seen
//   annul_i       EX -> div  abort the current op
//   result_o      div -> EX  {remainder, quotient}, registered
//   ready_o       div -> EX  result_o valid, registered
interface div_if #(
  parameter int DW = 32
);
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per clock, then one edge to apply the sign fix and
// publish {remainder, quotient}. EX stalls on start_i & ~ready_o.
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   bus   div_if.slave: signed_div_i, opdata1_i, opdata2_i, start_i,
//         annul_i in; result_o, ready_o out (both registered)
// Build option: define DIV_ZERO_FAST_EN to short-circuit a zero divisor
// through the DIVZERO state (result 0). Without it a zero divisor runs
// the full iteration (unsigned: quotient all ones, remainder = dividend).
module div_unit #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   rem_q, rem_d;      // partial remainder
  logic [DW-1:0]   dvd_q, dvd_d;      // dividend shifts out the top, quotient bits shift in
  logic [DW-1:0]   dvs_q, dvs_d;      // |divisor|
  logic            qneg_q, qneg_d;    // negate quotient at the end
  logic            rneg_q, rneg_d;    // negate remainder at the end
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  // Restoring step: DW+1-bit trial subtract of the divisor from the
  // shifted remainder.
  logic [DW:0]   rem_sh;
  logic          ge;
  logic [DW-1:0] rem_sub;
  logic [DW-1:0] q_fix, r_fix;

  assign rem_sh  = {rem_q, dvd_q[DW-1]};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  assign rem_sub = DW'(rem_sh - {1'b0, dvs_q});
  assign q_fix   = qneg_q ? -dvd_q : dvd_q;
  assign r_fix   = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          dvd_d  = (bus.signed_div_i && bus.opdata1_i[DW-1]) ? -bus.opdata1_i : bus.opdata1_i;
          dvs_d  = (bus.signed_div_i && bus.opdata2_i[DW-1]) ? -bus.opdata2_i : bus.opdata2_i;
          qneg_d = bus.signed_div_i && (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
          rneg_d = bus.signed_div_i && bus.opdata1_i[DW-1];
          rem_d  = '0;
          cnt_d  = '0;
          state_d = S_ON;
`ifdef DIV_ZERO_FAST_EN
          if (bus.opdata2_i == '0) state_d = S_DIVZERO;
`endif
        end
      end
      S_ON: begin
        // cnt reaches DW after the last step; that edge only fixes signs
        // and publishes the result.
        if (cnt_q == CNT_W'(DW)) begin
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
          state_d  = S_END;
        end else begin
          rem_d = ge ? rem_sub : rem_sh[DW-1:0];
          dvd_d = {dvd_q[DW-2:0], ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef DIV_ZERO_FAST_EN
      S_DIVZERO: begin
        // One wait edge keeps the zero-divisor result two edges after launch.
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = S_END;
        end
      end
`endif
      S_END: begin
        if (!bus.start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over completion on the same edge.
    if (bus.annul_i && state_q != S_IDLE) begin
      result_d = '0;
      ready_d  = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
